// File: rtl/fp_addsub_seq_if.sv
// Operand/result bundle for fp_addsub_seq: start/op/a/b in, busy/done/sum/flags out.
// Latency: none (pure signal grouping).
// Backpressure: none; the requester watches busy/done, a start while busy is dropped.
interface fp_addsub_seq_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         start;
  logic         op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         ovf;
  logic         invalid;

  modport master (output start, op, a, b, input busy, done, sum, ovf, invalid);
  modport slave  (input start, op, a, b, output busy, done, sum, ovf, invalid);
endinterface

// File: rtl/fp_addsub_seq.sv
// Sequential floating-point add/sub (EXP_W/MAN_W generic), G/R/S alignment; FPADD_RNE_EN selects RNE, else truncation.
// Latency: 2 cycles for specials, 4 for an exact zero result, 6..MAN_W+8 cycles for normal operands.
// Backpressure: one operation in flight; start is honoured only while idle, otherwise silently dropped.
module fp_addsub_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic           clk,
  input  logic           reset,
  fp_addsub_seq_if.slave bus
);
  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int SIG_W = MAN_W + 4;            // hidden + fraction + G,R,S
  localparam int M_W   = MAN_W + 5;            // SIG_W plus carry-out
  localparam int CNT_W = $clog2(MAN_W + 4);

  localparam logic [EXP_W-1:0] EXP_MAX   = '1;
  localparam logic [EXP_W-1:0] EXP_MAXF  = EXP_MAX - 1'b1;
  localparam logic [EXP_W:0]   SHIFT_LIM = (EXP_W+1)'(MAN_W + 3);
  localparam logic [CNT_W-1:0] NORM_MAX  = CNT_W'(MAN_W + 2);
  localparam logic [W-1:0]     QNAN      = {1'b0, EXP_MAX, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic               sign_q, sign_d;
  logic [EXP_W-1:0]   exp_q, exp_d;
  logic [M_W-1:0]     m_q, m_d;
  logic [SIG_W-1:0]   mb_q, mb_d;
  logic               eff_sub_q, eff_sub_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [W-1:0]       res_q, res_d;
  logic               rovf_q, rovf_d;
  logic               rinv_q, rinv_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [W-1:0]       sum_q, sum_d;
  logic               ovf_q, ovf_d;
  logic               inv_q, inv_d;

  // Operand field decode (b already carries the op-adjusted sign)
  logic             a_sign, b_sign;
  logic [EXP_W-1:0] a_exp, b_exp;
  logic [MAN_W-1:0] a_frac, b_frac;
  logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  assign a_sign = a_q[W-1];
  assign b_sign = b_q[W-1];
  assign a_exp  = a_q[W-2:MAN_W];
  assign b_exp  = b_q[W-2:MAN_W];
  assign a_frac = a_q[MAN_W-1:0];
  assign b_frac = b_q[MAN_W-1:0];
  assign a_zero = (a_exp == '0);
  assign b_zero = (b_exp == '0);
  assign a_inf  = (a_exp == EXP_MAX) && (a_frac == '0);
  assign b_inf  = (b_exp == EXP_MAX) && (b_frac == '0);
  assign a_nan  = (a_exp == EXP_MAX) && (a_frac != '0);
  assign b_nan  = (b_exp == EXP_MAX) && (b_frac != '0);

  // Alignment: pick the larger magnitude and shift the smaller right with sticky collection
  logic             a_ge;
  logic             big_sign;
  logic [EXP_W-1:0] big_exp, small_exp, diff;
  logic [SIG_W-1:0] big_sig, small_sig, sh_sig, small_al;
  logic             lost;

  always_comb begin
    a_ge      = {a_exp, a_frac} >= {b_exp, b_frac};
    big_sign  = a_ge ? a_sign : b_sign;
    big_exp   = a_ge ? a_exp : b_exp;
    small_exp = a_ge ? b_exp : a_exp;
    big_sig   = a_ge ? {1'b1, a_frac, 3'b000} : {1'b1, b_frac, 3'b000};
    small_sig = a_ge ? {1'b1, b_frac, 3'b000} : {1'b1, a_frac, 3'b000};
    diff      = big_exp - small_exp;
    sh_sig    = '0;
    lost      = 1'b0;
    small_al  = '0;
    if ({1'b0, diff} >= SHIFT_LIM) begin
      // Entirely below the round bits: only its presence survives, as sticky
      small_al = {{(SIG_W-1){1'b0}}, 1'b1};
    end else begin
      sh_sig   = small_sig >> diff;
      lost     = |(small_sig & ~({SIG_W{1'b1}} << diff));
      small_al = {sh_sig[SIG_W-1:1], sh_sig[0] | lost};
    end
  end

  // Significand add or subtract (larger magnitude is always in m_q, so never negative)
  logic [M_W-1:0] add_res;

  always_comb begin
    add_res = eff_sub_q ? (m_q - {1'b0, mb_q}) : (m_q + {1'b0, mb_q});
  end

  // Rounding of the normalised significand and post-round exponent/overflow detection
  logic             g_bit, r_bit, s_bit, lsb_bit, round_up;
  logic [MAN_W+1:0] mant_rnd;
  logic [EXP_W:0]   exp_rnd;
  logic [MAN_W-1:0] frac_rnd;
  logic             rnd_ovf;

  always_comb begin
    lsb_bit = m_q[3];
    g_bit   = m_q[2];
    r_bit   = m_q[1];
    s_bit   = m_q[0];
`ifdef FPADD_RNE_EN
    round_up = g_bit & (r_bit | s_bit | lsb_bit);
`else
    round_up = 1'b0;
`endif
    mant_rnd = {1'b0, m_q[MAN_W+3:3]} + {{(MAN_W+1){1'b0}}, round_up};
    exp_rnd  = {1'b0, exp_q} + {{EXP_W{1'b0}}, mant_rnd[MAN_W+1]};
    frac_rnd = mant_rnd[MAN_W+1] ? mant_rnd[MAN_W:1] : mant_rnd[MAN_W-1:0];
    rnd_ovf  = exp_rnd >= {1'b0, EXP_MAX};
  end

  // FSM next-state and datapath register updates
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sign_d    = sign_q;
    exp_d     = exp_q;
    m_d       = m_q;
    mb_d      = mb_q;
    eff_sub_d = eff_sub_q;
    cnt_d     = cnt_q;
    res_d     = res_q;
    rovf_d    = rovf_q;
    rinv_d    = rinv_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    sum_d     = sum_q;
    ovf_d     = ovf_q;
    inv_d     = inv_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b ^ {bus.op, {(W-1){1'b0}}};
          rovf_d  = 1'b0;
          rinv_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = S_UNPACK;
        end
      end
      S_UNPACK: begin
        state_d = S_DONE;
        if (a_nan || b_nan || (a_inf && b_inf && (a_sign != b_sign))) begin
          res_d  = QNAN;
          rinv_d = 1'b1;
        end else if (a_inf) begin
          res_d = a_q;
        end else if (b_inf) begin
          res_d = b_q;
        end else if (a_zero && b_zero) begin
          res_d = {a_sign & b_sign, {(W-1){1'b0}}};
        end else if (a_zero) begin
          res_d = b_q;
        end else if (b_zero) begin
          res_d = a_q;
        end else begin
          state_d = S_ALIGN;
        end
      end
      S_ALIGN: begin
        m_d       = {1'b0, big_sig};
        mb_d      = small_al;
        exp_d     = big_exp;
        sign_d    = big_sign;
        eff_sub_d = a_sign ^ b_sign;
        state_d   = S_ADD;
      end
      S_ADD: begin
        if (add_res == '0) begin
          res_d   = '0;
          state_d = S_DONE;
        end else begin
          m_d     = add_res;
          cnt_d   = '0;
          state_d = S_NORM;
        end
      end
      S_NORM: begin
        if (m_q[M_W-1]) begin
          // Carry-out: one right shift, keeping the dropped bit in sticky
          m_d   = {1'b0, m_q[M_W-1:2], m_q[1] | m_q[0]};
          exp_d = exp_q + 1'b1;
        end else if (m_q[M_W-2] || (cnt_q == NORM_MAX)) begin
          state_d = S_ROUND;
        end else if (exp_q <= EXP_W'(1)) begin
          // Would go subnormal: flush to signed zero
          res_d   = {sign_q, {(W-1){1'b0}}};
          state_d = S_DONE;
        end else begin
          m_d   = m_q << 1;
          exp_d = exp_q - 1'b1;
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_ROUND: begin
        if (rnd_ovf) begin
          rovf_d = 1'b1;
`ifdef FPADD_RNE_EN
          res_d  = {sign_q, EXP_MAX, {MAN_W{1'b0}}};
`else
          res_d  = {sign_q, EXP_MAXF, {MAN_W{1'b1}}};
`endif
        end else begin
          res_d = {sign_q, exp_rnd[EXP_W-1:0], frac_rnd};
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        sum_d   = res_q;
        ovf_d   = rovf_q;
        inv_d   = rinv_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      sign_q    <= 1'b0;
      exp_q     <= '0;
      m_q       <= '0;
      mb_q      <= '0;
      eff_sub_q <= 1'b0;
      cnt_q     <= '0;
      res_q     <= '0;
      rovf_q    <= 1'b0;
      rinv_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sum_q     <= '0;
      ovf_q     <= 1'b0;
      inv_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sign_q    <= sign_d;
      exp_q     <= exp_d;
      m_q       <= m_d;
      mb_q      <= mb_d;
      eff_sub_q <= eff_sub_d;
      cnt_q     <= cnt_d;
      res_q     <= res_d;
      rovf_q    <= rovf_d;
      rinv_q    <= rinv_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sum_q     <= sum_d;
      ovf_q     <= ovf_d;
      inv_q     <= inv_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.sum     = sum_q;
  assign bus.ovf     = ovf_q;
  assign bus.invalid = inv_q;

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Directed bench for fp_addsub_seq (EXP_W=8, MAN_W=23); expected sums are hand-computed binary32 values.
// Rounding expectations follow FPADD_RNE_EN when it is defined for the build.
// Each op: drive start on a negedge, sample 1 time unit after each rising edge.
module tb_fp_addsub_seq;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad   = 0;

  fp_addsub_seq_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();

  fp_addsub_seq #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Launch one operation; lat = rising edges from the start edge until done is seen (999 = never)
  task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input logic opv,
                        output int lat, output logic busy0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    bus.op    = opv;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    busy0     = bus.busy;
    lat       = 0;
    while (bus.done !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (bus.done !== 1'b1) lat = 999;
  endtask

  initial begin
    int   lat;
    int   extra;
    logic busy0;
    logic [31:0] exp_rnd, exp_max;

    bus.start = 1'b0;
    bus.op    = 1'b0;
    bus.a     = '0;
    bus.b     = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {bus.busy, bus.done, bus.sum, bus.ovf, bus.invalid}, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // 1.0 + 2.0 = 3.0, minimum normal latency
    run_op(32'h3F800000, 32'h40000000, 1'b0, lat, busy0);
    check("add_busy_after_start", busy0, 1);
    check("add_latency", lat, 6);
    check("add_sum", bus.sum, 32'h40400000);
    check("add_flags", {bus.ovf, bus.invalid}, 0);
    check("add_busy_at_done", bus.busy, 0);
    @(posedge clk);
    #1;
    check("add_done_one_cycle", bus.done, 0);

    // 5.0 - 5.0 = +0
    run_op(32'h40A00000, 32'h40A00000, 1'b1, lat, busy0);
    check("cancel_done_seen", lat != 999, 1);
    check("cancel_sum", bus.sum, 32'h00000000);

    // inf - inf -> qNaN, invalid, 2-cycle latency
    run_op(32'h7F800000, 32'h7F800000, 1'b1, lat, busy0);
    check("infinf_latency", lat, 2);
    check("infinf_sum", bus.sum, 32'h7FC00000);
    check("infinf_invalid", bus.invalid, 1);

    // Above-half rounding case
`ifdef FPADD_RNE_EN
    exp_rnd = 32'h3F800001;
    exp_max = 32'h7F800000;
`else
    exp_rnd = 32'h3F800000;
    exp_max = 32'h7F7FFFFF;
`endif
    run_op(32'h3F800000, 32'h33C00000, 1'b0, lat, busy0);
    check("round_above_half", bus.sum, exp_rnd);

    // Exact tie to even stays at 1.0
    run_op(32'h3F800000, 32'h33800000, 1'b0, lat, busy0);
    check("round_tie_even", bus.sum, 32'h3F800000);

    // max finite + max finite overflows
    run_op(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, lat, busy0);
    check("ovf_sum", bus.sum, exp_max);
    check("ovf_flag", bus.ovf, 1);
    check("ovf_invalid", bus.invalid, 0);

    // 1.0 - 2.0 = -1.0 (swap + sign of larger)
    run_op(32'h3F800000, 32'h40000000, 1'b1, lat, busy0);
    check("sub_neg_sum", bus.sum, 32'hBF800000);
    check("sub_neg_flags", {bus.ovf, bus.invalid}, 0);

    // NaN operand
    run_op(32'h7F800001, 32'h3F800000, 1'b0, lat, busy0);
    check("nan_sum", bus.sum, 32'h7FC00000);
    check("nan_invalid", bus.invalid, 1);

    // inf + finite
    run_op(32'h7F800000, 32'h3F800000, 1'b0, lat, busy0);
    check("inf_fin_sum", bus.sum, 32'h7F800000);
    check("inf_fin_invalid", bus.invalid, 0);

    // Zero cases
    run_op(32'h00000000, 32'hC0400000, 1'b0, lat, busy0);
    check("zero_plus_x", bus.sum, 32'hC0400000);
    run_op(32'h80000000, 32'h80000000, 1'b0, lat, busy0);
    check("negzero_negzero", bus.sum, 32'h80000000);
    run_op(32'h00000000, 32'h80000000, 1'b0, lat, busy0);
    check("poszero_negzero", bus.sum, 32'h00000000);

    // Long normalisation: (1+2^-23) - 1 = 2^-23
    run_op(32'h3F800001, 32'h3F800000, 1'b1, lat, busy0);
    check("longnorm_sum", bus.sum, 32'h34000000);
    check("longnorm_latency_range", (lat >= 6) && (lat <= MAN_W + 8), 1);

    // Start while busy is ignored
    @(negedge clk);
    bus.start = 1'b1; bus.a = 32'h3F800000; bus.b = 32'h40000000; bus.op = 1'b0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.a = 32'h40A00000; bus.b = 32'h40A00000; bus.op = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat = 0;
    while (bus.done !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("busy_start_done_seen", bus.done, 1);
    check("busy_start_sum", bus.sum, 32'h40400000);
    extra = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) extra++;
    end
    check("busy_start_no_second_done", extra, 0);

    // Reset in the middle of a long normalisation
    @(negedge clk);
    bus.start = 1'b1; bus.a = 32'h3F800001; bus.b = 32'h3F800000; bus.op = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("midreset_outputs", {bus.busy, bus.done, bus.sum, bus.ovf, bus.invalid}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    extra = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) extra++;
    end
    check("midreset_no_done", extra, 0);
    check("midreset_sum_held_zero", bus.sum, 32'h00000000);

    // Normal operation resumes after the abort
    run_op(32'h3F800000, 32'h40000000, 1'b0, lat, busy0);
    check("post_reset_sum", bus.sum, 32'h40400000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
